snoop_fifo_arbiter: RTL and testbench
=====================================

Name: snoop_fifo_arbiter

Overview:
- Shares the single XGMII-TX snoop FIFO write port (72-bit din/wr_en/full) between two snoop record sources, e.g. the RX-path and TX-path TLP snoopers.
- Arbitrates per record, round-robin: a granted source keeps the FIFO until its record's last word is written.
- An idle watchdog terminates records that stall mid-stream, so a hung source cannot lock the FIFO.

Parameters:
- IdleTimeout, 8'd32: consecutive cycles with no valid word from the granted source (mid-record) before the record is aborted. Legal range 1..255.
- StartBit, 68: din bit index marking the first word of a record.
- LastBit, 65: din bit index marking the last word of a record.
- AbortBit, 69: din bit index set in the arbiter-generated abort word.

Ports:
- clk  in  1  single clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- s0_din  in  72  source 0 word (b63-0 data, b67-66 lane enables, StartBit, LastBit).
- s0_valid  in  1  source 0 word valid.
- s0_ready  out  1  source 0 word accepted this cycle when high with s0_valid.
- s1_din  in  72  source 1 word, same format.
- s1_valid  in  1  source 1 word valid.
- s1_ready  out  1  source 1 accept.
- full  in  1  FIFO programmable-full; must assert with at least 1 free entry remaining.
- din  out  72  FIFO write data (registered).
- wr_en  out  1  FIFO write strobe (registered).
- grant  out  2  one-hot current owner; 2'b00 in IDLE.

Behaviour:
- Reset (asynchronous, sys_rst=1):
  - din=0, wr_en=0, s0_ready=s1_ready=0, grant=0.
  - state=IDLE, last_winner=1 (source 0 wins first), idle counter=0.
- s*_ready are combinational from state, grant and full. din and wr_en are registered: a word accepted in cycle N appears with wr_en=1 in cycle N+1. wr_en=0 in every other cycle.
- IDLE:
  - Eligible source: valid=1 and din[StartBit]=1.
  - Both eligible: grant the source that is not last_winner. One eligible: grant it.
  - Next state XFER. No word is accepted in the arbitration cycle.
  - A source that is valid with StartBit=0 gets ready=1 and its word is discarded (resync). This happens only when no other source is eligible that cycle.
- XFER:
  - ready(granted) = !full; the other source's ready=0.
  - On accept: forward the word, clear the idle counter.
  - If the accepted word has LastBit=1: last_winner<=owner, next state IDLE.
  - A word with StartBit=1 mid-record is forwarded unchanged.
  - If the granted source's valid=0: the idle counter increments. When it reaches IdleTimeout, next state ABORT.
  - full=1 with valid=1 does not count as idle.
- ABORT:
  - When !full, write the abort word: all zeros except AbortBit=1 and LastBit=1. Next state FLUSH.
  - Sources are not ready in this state.
- FLUSH:
  - Granted source has ready=1 regardless of full; its words are discarded.
  - On an accepted word with LastBit=1: last_winner<=owner, next state IDLE.
- A single-word record (StartBit=1 and LastBit=1) completes XFER in one accept.
- No back-to-back hold: after a record completes, IDLE always re-arbitrates.
- Idle counter width is 8 bits and saturates; it is cleared on entry to XFER.

Optional Feature:
- Macro: SNOOP_ARB_STATS_EN.
- Enabled, adds outputs, all reset to 0 by sys_rst and wrapping modulo 2^32:
  - rec_cnt0 [31:0], rec_cnt1 [31:0]: count records completed normally per source.
  - abort_cnt [31:0]: counts ABORT entries.
  - resync_cnt [31:0]: counts words discarded in IDLE.
- Disabled: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Source 0 sends a 3-word record, full=0 -> wr_en high 3 cycles, starting the cycle after the first accept; din matches; grant=01 then 00.
- Both sources assert a start word simultaneously from reset -> source 0 served first, then source 1. Repeat -> order alternates 0,1,0,1.
- full=1 asserted for 4 cycles mid-record -> s0_ready=0 and wr_en=0 for those cycles, no word lost or duplicated, idle counter not advanced.
- IdleTimeout=4; source 1 stalls after word 1 -> after 4 idle cycles din=bit69|bit65 with wr_en=1. Remaining words through LastBit are discarded; abort_cnt=1 when STATS_EN.
- Source 0 valid with StartBit=0 in IDLE -> word consumed, wr_en stays 0, resync_cnt increments.
- sys_rst pulsed mid-record (asynchronously, between edges) -> wr_en, ready and grant drop to 0 immediately; after release, arbitration restarts with source 0 priority.

Source files
------------

// File: rtl/snoop_fifo_arbiter.sv
// Round-robin per-record arbiter sharing one snoop FIFO write port.
// Optional statistics counters: define SNOOP_ARB_STATS_EN.
module snoop_fifo_arbiter #(
  parameter logic [7:0] IdleTimeout = 8'd32,
  parameter int         StartBit    = 68,
  parameter int         LastBit     = 65,
  parameter int         AbortBit    = 69
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic [71:0] s0_din,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [71:0] s1_din,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic        full,
  output logic [71:0] din,
  output logic        wr_en,
  output logic [1:0]  grant
`ifdef SNOOP_ARB_STATS_EN
  ,
  output logic [31:0] rec_cnt0,
  output logic [31:0] rec_cnt1,
  output logic [31:0] abort_cnt,
  output logic [31:0] resync_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    ABORT,
    FLUSH
  } state_e;

  localparam logic [71:0] AbortWord =
    (72'd1 << AbortBit) | (72'd1 << LastBit);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        lw_q, lw_d;
  logic [7:0]  idle_q, idle_d;
  logic [71:0] din_q, din_d;
  logic        wr_q, wr_d;

  logic        elig0, elig1;
  logic        g_valid;
  logic [71:0] g_din;
  logic [7:0]  idle_inc;
  logic        rdy0, rdy1;
  logic        rec_done;
  logic        abort_go;
  logic [1:0]  resync;

  assign elig0    = s0_valid & s0_din[StartBit];
  assign elig1    = s1_valid & s1_din[StartBit];
  assign g_valid  = owner_q ? s1_valid : s0_valid;
  assign g_din    = owner_q ? s1_din : s0_din;
  assign idle_inc = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;

  // Next-state, ready and write-data decode
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    lw_d     = lw_q;
    idle_d   = idle_q;
    din_d    = din_q;
    wr_d     = 1'b0;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    rec_done = 1'b0;
    abort_go = 1'b0;
    resync   = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          state_d = XFER;
          idle_d  = 8'd0;
          owner_d = (elig0 && elig1) ? ~lw_q : elig1;
        end else begin
          // nothing eligible: any valid word is mid-record junk
          rdy0   = s0_valid;
          rdy1   = s1_valid;
          resync = {s1_valid, s0_valid};
        end
      end
      XFER: begin
        if (owner_q) rdy1 = ~full;
        else         rdy0 = ~full;
        if (g_valid && !full) begin
          din_d  = g_din;
          wr_d   = 1'b1;
          idle_d = 8'd0;
          if (g_din[LastBit]) begin
            lw_d     = owner_q;
            state_d  = IDLE;
            rec_done = 1'b1;
          end
        end else if (!g_valid) begin
          idle_d = idle_inc;
          if (idle_inc >= IdleTimeout) begin
            state_d  = ABORT;
            abort_go = 1'b1;
          end
        end
      end
      ABORT: begin
        if (!full) begin
          din_d   = AbortWord;
          wr_d    = 1'b1;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // drain the stalled record without touching the FIFO
        if (owner_q) rdy1 = 1'b1;
        else         rdy0 = 1'b1;
        if (g_valid && g_din[LastBit]) begin
          lw_d    = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state and registered FIFO write port
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      lw_q    <= 1'b1;
      idle_q  <= 8'd0;
      din_q   <= 72'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lw_q    <= lw_d;
      idle_q  <= idle_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
    end
  end

  assign s0_ready = rdy0 & ~sys_rst;
  assign s1_ready = rdy1 & ~sys_rst;
  assign din      = din_q;
  assign wr_en    = wr_q;
  assign grant    = (state_q == IDLE) ? 2'b00 :
                    (owner_q ? 2'b10 : 2'b01);

`ifdef SNOOP_ARB_STATS_EN
  logic [31:0] rec0_q, rec1_q, abort_q, resync_q;

  // Record, abort and resync event counters
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      rec0_q   <= 32'd0;
      rec1_q   <= 32'd0;
      abort_q  <= 32'd0;
      resync_q <= 32'd0;
    end else begin
      if (rec_done && !owner_q) rec0_q <= rec0_q + 32'd1;
      if (rec_done && owner_q)  rec1_q <= rec1_q + 32'd1;
      if (abort_go) abort_q <= abort_q + 32'd1;
      resync_q <= resync_q + 32'(resync[0]) + 32'(resync[1]);
    end
  end

  assign rec_cnt0   = rec0_q;
  assign rec_cnt1   = rec1_q;
  assign abort_cnt  = abort_q;
  assign resync_cnt = resync_q;
`else
  logic unused_stats;
  assign unused_stats = ^{rec_done, abort_go, resync};
`endif

endmodule

// File: tb/tb_snoop_fifo_arbiter.sv
// Directed and randomized bench for snoop_fifo_arbiter.
// Reference: per-source record queues and round-robin order.
module tb_snoop_fifo_arbiter;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [71:0] s0_din, s1_din;
  logic        s0_valid, s1_valid;
  logic        s0_ready, s1_ready;
  logic        full;
  logic [71:0] din;
  logic        wr_en;
  logic [1:0]  grant;
`ifdef SNOOP_ARB_STATS_EN
  logic [31:0] rec_cnt0, rec_cnt1, abort_cnt, resync_cnt;
`endif

  snoop_fifo_arbiter #(.IdleTimeout(8'd4)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .s0_din(s0_din), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_din(s1_din), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .full(full), .din(din), .wr_en(wr_en), .grant(grant)
`ifdef SNOOP_ARB_STATS_EN
    , .rec_cnt0(rec_cnt0), .rec_cnt1(rec_cnt1)
    , .abort_cnt(abort_cnt), .resync_cnt(resync_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  logic [71:0] wq[$];

  localparam logic [71:0] ABW = (72'd1 << 69) | (72'd1 << 65);

  // capture every FIFO write
  always @(negedge clk) if (wr_en) wq.push_back(din);

  task automatic chk(string tag, logic [71:0] obs, logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(string tag, int obs, int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_q(string tag, logic [71:0] e[$]);
    chk_i({tag, " len"}, wq.size(), e.size());
    for (int i = 0; i < e.size() && i < wq.size(); i++)
      chk(tag, wq[i], e[i]);
    wq.delete();
  endtask

  function automatic logic [71:0] mk(logic src, logic st, logic ls);
    logic [71:0] w;
    w = '0;
    w[31:0]  = $urandom;
    w[62:32] = 31'($urandom);
    w[63]    = src;
    w[65]    = ls;
    w[67:66] = 2'($urandom);
    w[68]    = st;
    return w;
  endfunction

  task automatic drv(logic v0, logic [71:0] d0,
                     logic v1, logic [71:0] d1, logic f);
    @(negedge clk);
    s0_valid = v0; s0_din = d0;
    s1_valid = v1; s1_din = d1;
    full = f;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    sys_rst = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0; full = 1'b0;
    @(negedge clk);
    sys_rst = 1'b0;
    #1;
    wq.delete();
  endtask

  logic [71:0] a0, a1, a2, b0, b1, b2, b3, c0, c1, x;
  logic [71:0] e[$];
  logic [71:0] sq0[$], sq1[$], e0[$], e1[$];
  logic acc0, acc1;
  int cyc, len, exp_src, cur_src;

  initial begin
    sys_rst = 1'b1;
    full = 1'b0;
    s0_valid = 1'b1; s0_din = '0;
    s1_valid = 1'b0; s1_din = '0;

    // reset state
    @(negedge clk); @(negedge clk); #1;
    chk_i("rst wr_en", int'(wr_en), 0);
    chk("rst din", din, '0);
    chk_i("rst s0_ready", int'(s0_ready), 0);
    chk_i("rst s1_ready", int'(s1_ready), 0);
    chk_i("rst grant", int'(grant), 0);
    @(negedge clk);
    s0_valid = 1'b0;
    sys_rst = 1'b0;
    #1; wq.delete();

    // 3-word record from source 0
    a0 = mk(0, 1, 0); a1 = mk(0, 0, 0); a2 = mk(0, 0, 1);
    drv(1, a0, 0, '0, 0);
    chk_i("t1 arb grant", int'(grant), 0);
    chk_i("t1 arb ready", int'(s0_ready), 0);
    drv(1, a0, 0, '0, 0);
    chk_i("t1 grant", int'(grant), 1);
    chk_i("t1 ready", int'(s0_ready), 1);
    chk_i("t1 wr_en0", int'(wr_en), 0);
    drv(1, a1, 0, '0, 0);
    chk_i("t1 wr_en1", int'(wr_en), 1);
    chk("t1 din0", din, a0);
    drv(1, a2, 0, '0, 0);
    chk("t1 din1", din, a1);
    drv(0, '0, 0, '0, 0);
    chk_i("t1 wr_en3", int'(wr_en), 1);
    chk("t1 din2", din, a2);
    chk_i("t1 grant end", int'(grant), 0);
    drv(0, '0, 0, '0, 0);
    chk_i("t1 wr_en off", int'(wr_en), 0);
    e = '{a0, a1, a2};
    chk_q("t1 stream", e);

    // contention from reset: 0,1,0,1
    do_reset();
    c0 = mk(0, 1, 1); c1 = mk(1, 1, 1);
    e = {};
    for (int k = 0; k < 4; k++) begin
      drv(1, c0, 1, c1, 0);
      chk_i("t2 arb grant", int'(grant), 0);
      chk_i("t2 arb rdy", int'({s1_ready, s0_ready}), 0);
      drv(1, c0, 1, c1, 0);
      chk_i("t2 grant", int'(grant), (k % 2 == 0) ? 1 : 2);
      chk_i("t2 ready", int'({s1_ready, s0_ready}),
            (k % 2 == 0) ? 1 : 2);
      if (k % 2 == 0) begin e.push_back(c0); c0 = mk(0, 1, 1); end
      else begin e.push_back(c1); c1 = mk(1, 1, 1); end
    end
    drv(0, '0, 0, '0, 0);
    drv(0, '0, 0, '0, 0);
    chk_q("t2 stream", e);

    // full back-pressure mid-record
    a0 = mk(0, 1, 0); a1 = mk(0, 0, 0); a2 = mk(0, 0, 1);
    drv(1, a0, 0, '0, 0);
    drv(1, a0, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      drv(1, a1, 0, '0, 1);
      chk_i("t3 ready full", int'(s0_ready), 0);
      chk_i("t3 grant", int'(grant), 1);
      if (i > 0) chk_i("t3 wr_en full", int'(wr_en), 0);
    end
    drv(1, a1, 0, '0, 0);
    chk_i("t3 ready resume", int'(s0_ready), 1);
    drv(1, a2, 0, '0, 0);
    drv(0, '0, 0, '0, 0);
    drv(0, '0, 0, '0, 0);
    e = '{a0, a1, a2};
    chk_q("t3 stream", e);

    // idle watchdog abort on source 1
    b0 = mk(1, 1, 0); b1 = mk(1, 0, 0);
    b2 = mk(1, 0, 0); b3 = mk(1, 0, 1);
    drv(0, '0, 1, b0, 0);
    drv(0, '0, 1, b0, 0);
    drv(0, '0, 1, b1, 0);
    for (int i = 0; i < 4; i++) begin
      drv(0, '0, 0, '0, 0);
      chk_i("t4 grant idle", int'(grant), 2);
    end
    drv(0, '0, 1, b2, 0);
    chk_i("t4 abort ready", int'(s1_ready), 0);
    drv(0, '0, 1, b2, 1);
    chk_i("t4 flush ready", int'(s1_ready), 1);
    chk_i("t4 abort wr", int'(wr_en), 1);
    chk("t4 abort word", din, ABW);
    drv(0, '0, 1, b3, 0);
    chk_i("t4 flush ready2", int'(s1_ready), 1);
    drv(0, '0, 0, '0, 0);
    chk_i("t4 grant end", int'(grant), 0);
    chk_i("t4 wr_en end", int'(wr_en), 0);
    e = '{b0, b1, ABW};
    chk_q("t4 stream", e);
`ifdef SNOOP_ARB_STATS_EN
    chk_i("t4 abort_cnt", int'(abort_cnt), 1);
`endif

    // resync discard in IDLE
    x = mk(0, 0, 0);
    drv(1, x, 0, '0, 0);
    chk_i("t5 resync ready", int'(s0_ready), 1);
    drv(0, '0, 0, '0, 0);
    chk_i("t5 resync wr", int'(wr_en), 0);
    chk_i("t5 grant", int'(grant), 0);
    c1 = mk(1, 1, 1);
    drv(1, x, 1, c1, 0);
    chk_i("t5 no resync", int'(s0_ready), 0);
    drv(1, x, 1, c1, 0);
    chk_i("t5 grant s1", int'(grant), 2);
    chk_i("t5 rdy", int'({s1_ready, s0_ready}), 2);
    drv(1, x, 0, '0, 0);
    chk_i("t5 resync2", int'(s0_ready), 1);
    drv(0, '0, 0, '0, 0);
    e = '{c1};
    chk_q("t5 stream", e);
`ifdef SNOOP_ARB_STATS_EN
    chk_i("t5 resync_cnt", int'(resync_cnt), 2);
    chk_i("t5 rec_cnt0", int'(rec_cnt0), 3);
    chk_i("t5 rec_cnt1", int'(rec_cnt1), 3);
`endif

    // asynchronous reset mid-record
    a0 = mk(0, 1, 0); a1 = mk(0, 0, 1);
    drv(1, a0, 0, '0, 0);
    drv(1, a0, 0, '0, 0);
    drv(1, a1, 0, '0, 0);
    chk_i("t6 pre wr", int'(wr_en), 1);
    #2 sys_rst = 1'b1;
    #1;
    chk_i("t6 rst wr_en", int'(wr_en), 0);
    chk_i("t6 rst ready", int'(s0_ready), 0);
    chk_i("t6 rst grant", int'(grant), 0);
    @(negedge clk);
    sys_rst = 1'b0;
    #1; wq.delete();
    c0 = mk(0, 1, 1); c1 = mk(1, 1, 1);
    drv(1, c0, 1, c1, 0);
    chk_i("t6 arb", int'(grant), 0);
    drv(1, c0, 1, c1, 0);
    chk_i("t6 s0 first", int'(grant), 1);
    drv(0, '0, 1, c1, 0);
    drv(0, '0, 1, c1, 0);
    chk_i("t6 s1 next", int'(grant), 2);
    drv(0, '0, 0, '0, 0);
    drv(0, '0, 0, '0, 0);
    e = '{c0, c1};
    chk_q("t6 stream", e);

    // randomized records with random back-pressure
    do_reset();
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++)
        sq0.push_back(mk(0, j == 0, j == len - 1));
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++)
        sq1.push_back(mk(1, j == 0, j == len - 1));
    end
    e0 = sq0; e1 = sq1;
    cyc = 0;
    while ((sq0.size() > 0 || sq1.size() > 0) && cyc < 3000) begin
      @(negedge clk);
      full = ($urandom_range(0, 3) == 0);
      s0_valid = (sq0.size() > 0);
      s0_din = s0_valid ? sq0[0] : '0;
      s1_valid = (sq1.size() > 0);
      s1_din = s1_valid ? sq1[0] : '0;
      #1;
      acc0 = s0_valid & s0_ready;
      acc1 = s1_valid & s1_ready;
      @(posedge clk);
      if (acc0) void'(sq0.pop_front());
      if (acc1) void'(sq1.pop_front());
      cyc++;
    end
    chk_i("rand drained", sq0.size() + sq1.size(), 0);
    drv(0, '0, 0, '0, 0);
    drv(0, '0, 0, '0, 0);
    exp_src = 0;
    cur_src = 0;
    foreach (wq[i]) begin
      if (wq[i][68]) begin
        chk_i("rand rr order", int'(wq[i][63]), exp_src);
        cur_src = int'(wq[i][63]);
        exp_src = 1 - cur_src;
      end else begin
        chk_i("rand interleave", int'(wq[i][63]), cur_src);
      end
      if (wq[i][63]) begin
        if (e1.size() > 0) chk("rand word s1", wq[i], e1.pop_front());
        else chk("rand extra s1", wq[i], '0);
      end else begin
        if (e0.size() > 0) chk("rand word s0", wq[i], e0.pop_front());
        else chk("rand extra s0", wq[i], '0);
      end
    end
    chk_i("rand s0 left", e0.size(), 0);
    chk_i("rand s1 left", e1.size(), 0);
`ifdef SNOOP_ARB_STATS_EN
    chk_i("rand rec_cnt0", int'(rec_cnt0), 8);
    chk_i("rand rec_cnt1", int'(rec_cnt1), 8);
    chk_i("rand abort_cnt", int'(abort_cnt), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
